// File: rtl/dmac_ahb_slv.sv
// AHB-Lite word-memory responder with configurable wait states and a completed-transfer counter.
// Define DMAC_AHB_SLV_ERR_EN to return two-cycle ERROR responses for out-of-range, unaligned or non-word transfers.
module dmac_ahb_slv #(
   parameter int DEPTH       = 256,
   parameter int AW          = 8,
   parameter int WAIT_CYCLES = 1
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        hsel,
   input  logic [1:0]  htrans,
   input  logic [2:0]  hsize,
   input  logic        hwrite,
   input  logic [31:0] haddr,
   input  logic [31:0] hwdata,
   input  logic        hready,
   output logic        hreadyout,
   output logic        hresp,
   output logic [31:0] hrdata,
   output logic [15:0] xfer_cnt
);

   typedef enum logic [1:0] {
      S_IDLE,
      S_ACCESS,
      S_ERR1,
      S_ERR2
   } state_e;

   state_e        state_q, state_d;
   logic [AW-1:0] addr_q, addr_d;
   logic          write_q, write_d;
   logic [3:0]    wcnt_q, wcnt_d;
   logic [15:0]   xfer_cnt_q, xfer_cnt_d;
   logic          accept, err_flag, take_new, mem_we;
   logic [31:0]   mem [DEPTH];

   assign accept   = hsel & htrans[1] & hready;
   assign xfer_cnt = xfer_cnt_q;

`ifdef DMAC_AHB_SLV_ERR_EN
   assign err_flag = (haddr[31:AW+2] != '0) | (haddr[1:0] != 2'b00) | (hsize != 3'b010);
`else
   logic unused_addr_size;
   assign err_flag         = 1'b0;
   assign unused_addr_size = ^{hsize, haddr[31:AW+2], haddr[1:0]};
`endif

   // NOTE: every always_comb output gets a default before the case so no path can infer a latch.
   always_comb begin
      state_d    = state_q;
      addr_d     = addr_q;
      write_d    = write_q;
      wcnt_d     = wcnt_q;
      xfer_cnt_d = xfer_cnt_q;
      hreadyout  = 1'b1;
      hresp      = 1'b0;
      hrdata     = 32'h0;
      mem_we     = 1'b0;
      take_new   = 1'b0;
      case (state_q)
         S_IDLE: take_new = 1'b1;
         S_ACCESS: begin
            if (wcnt_q != 4'd0) begin
               hreadyout = 1'b0;
               wcnt_d    = wcnt_q - 4'd1;
            end else begin
               if (write_q) mem_we = 1'b1;
               else         hrdata = mem[addr_q];
               xfer_cnt_d = xfer_cnt_q + 16'd1;
               state_d    = S_IDLE;
               take_new   = 1'b1;
            end
         end
         S_ERR1: begin
            hresp     = 1'b1;
            hreadyout = 1'b0;
            state_d   = S_ERR2;
         end
         S_ERR2: begin
            hresp    = 1'b1;
            state_d  = S_IDLE;
            take_new = 1'b1;
         end
         default: state_d = S_IDLE;
      endcase
      // Completion cycles double as the next address phase, giving bubble-free pipelining.
      if (take_new && accept) begin
         addr_d  = haddr[AW+1:2];
         write_d = hwrite;
         wcnt_d  = 4'(WAIT_CYCLES);
         state_d = err_flag ? S_ERR1 : S_ACCESS;
      end
   end

   // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= S_IDLE;
         addr_q     <= '0;
         write_q    <= 1'b0;
         wcnt_q     <= 4'd0;
         xfer_cnt_q <= 16'd0;
      end else begin
         state_q    <= state_d;
         addr_q     <= addr_d;
         write_q    <= write_d;
         wcnt_q     <= wcnt_d;
         xfer_cnt_q <= xfer_cnt_d;
      end
   end

   // NOTE: the memory array has no reset so it maps onto plain RAM; rst only blocks a pending write.
   always_ff @(posedge clk) begin
      if (mem_we && !rst) mem[addr_q] <= hwdata;
   end

endmodule

// File: tb/tb_dmac_ahb_slv.sv
// Directed bench for dmac_ahb_slv: one instance with one wait state, one zero-wait instance for pipelining.
module tb_dmac_ahb_slv;

   logic        clk = 1'b0;
   logic        rst;
   logic        hsel, hsel0;
   logic [1:0]  htrans;
   logic [2:0]  hsize;
   logic        hwrite;
   logic [31:0] haddr, hwdata;
   logic        hready, hreadyout, hresp;
   logic [31:0] hrdata;
   logic [15:0] xfer_cnt;
   logic        hready0, hreadyout0, hresp0;
   logic [31:0] hrdata0;
   logic [15:0] xfer_cnt0;

   int n_cmp = 0;
   int n_err = 0;
   logic [15:0] exp_cnt;

   always #5 clk = ~clk;

   assign hready  = hreadyout;
   assign hready0 = hreadyout0;

   dmac_ahb_slv #(.DEPTH(256), .AW(8), .WAIT_CYCLES(1)) u_dut (
      .clk(clk), .rst(rst), .hsel(hsel), .htrans(htrans), .hsize(hsize), .hwrite(hwrite),
      .haddr(haddr), .hwdata(hwdata), .hready(hready), .hreadyout(hreadyout), .hresp(hresp),
      .hrdata(hrdata), .xfer_cnt(xfer_cnt)
   );

   dmac_ahb_slv #(.DEPTH(256), .AW(8), .WAIT_CYCLES(0)) u_dut0 (
      .clk(clk), .rst(rst), .hsel(hsel0), .htrans(htrans), .hsize(hsize), .hwrite(hwrite),
      .haddr(haddr), .hwdata(hwdata), .hready(hready0), .hreadyout(hreadyout0), .hresp(hresp0),
      .hrdata(hrdata0), .xfer_cnt(xfer_cnt0)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Non-pipelined transfer on u_dut; reports wait cycles seen and the response/data of the data phase.
   task automatic bus_xfer(input logic wr, input logic [31:0] addr, input logic [31:0] wdata,
                           output int waits, output logic [31:0] rdata,
                           output logic resp_first, output logic resp_last);
      hsel = 1'b1; htrans = 2'b10; hwrite = wr; haddr = addr; hsize = 3'b010;
      tick();
      hsel = 1'b0; htrans = 2'b00; hwrite = 1'b0; hwdata = wdata;
      resp_first = hresp;
      waits = 0;
      while (hreadyout !== 1'b1 && waits < 20) begin
         waits++;
         tick();
      end
      rdata     = hrdata;
      resp_last = hresp;
      tick();
   endtask

   task automatic test_reset();
      rst = 1'b1;
      repeat (2) tick();
      n_cmp++; if (hreadyout !== 1'b1) begin n_err++; $display("FAIL reset_hreadyout got %b want 1", hreadyout); end
      n_cmp++; if (hresp !== 1'b0) begin n_err++; $display("FAIL reset_hresp got %b want 0", hresp); end
      n_cmp++; if (hrdata !== 32'h0) begin n_err++; $display("FAIL reset_hrdata got %h want 0", hrdata); end
      n_cmp++; if (xfer_cnt !== 16'h0) begin n_err++; $display("FAIL reset_xfer_cnt got %0d want 0", xfer_cnt); end
      n_cmp++; if (xfer_cnt0 !== 16'h0) begin n_err++; $display("FAIL reset_xfer_cnt0 got %0d want 0", xfer_cnt0); end
      rst = 1'b0;
      exp_cnt = 16'd0;
   endtask

   task automatic test_write_read();
      int w; logic [31:0] rd; logic r0, r1;
      bus_xfer(1'b1, 32'h10, 32'hDEADBEEF, w, rd, r0, r1);
      exp_cnt++;
      n_cmp++; if (w !== 1) begin n_err++; $display("FAIL wr_waits got %0d want 1", w); end
      bus_xfer(1'b0, 32'h10, 32'h0, w, rd, r0, r1);
      exp_cnt++;
      n_cmp++; if (w !== 1) begin n_err++; $display("FAIL rd_waits got %0d want 1", w); end
      n_cmp++; if (rd !== 32'hDEADBEEF) begin n_err++; $display("FAIL rd_data got %h want deadbeef", rd); end
      n_cmp++; if (xfer_cnt !== exp_cnt) begin n_err++; $display("FAIL wr_rd_cnt got %0d want %0d", xfer_cnt, exp_cnt); end
   endtask

   task automatic test_back_to_back();
      logic [31:0] exp_rd;
      hsize = 3'b010;
      for (int i = 0; i <= 6; i++) begin
         if (i < 6) begin
            hsel0 = 1'b1; htrans = 2'b10; hwrite = (i < 3);
            haddr = 32'((i % 3) * 4);
         end else begin
            hsel0 = 1'b0; htrans = 2'b00; hwrite = 1'b0;
         end
         if (i >= 1 && i <= 3) hwdata = 32'(i);
         n_cmp++; if (hreadyout0 !== 1'b1) begin n_err++; $display("FAIL b2b_ready beat %0d got %b want 1", i, hreadyout0); end
         if (i >= 4) begin
            exp_rd = 32'(i - 3);
            n_cmp++; if (hrdata0 !== exp_rd) begin n_err++; $display("FAIL b2b_rdata beat %0d got %h want %h", i, hrdata0, exp_rd); end
         end
         tick();
      end
      n_cmp++; if (xfer_cnt0 !== 16'd6) begin n_err++; $display("FAIL b2b_cnt got %0d want 6", xfer_cnt0); end
   endtask

   task automatic test_error();
      int w; logic [31:0] rd; logic r0, r1;
      bus_xfer(1'b1, 32'h0, 32'h77, w, rd, r0, r1);
      exp_cnt++;
      bus_xfer(1'b1, 32'h1000, 32'h5, w, rd, r0, r1);
`ifdef DMAC_AHB_SLV_ERR_EN
      n_cmp++; if (w !== 1) begin n_err++; $display("FAIL err_waits got %0d want 1", w); end
      n_cmp++; if ({r0, r1} !== 2'b11) begin n_err++; $display("FAIL err_resp got %b want 11", {r0, r1}); end
`else
      exp_cnt++;
      n_cmp++; if (w !== 1) begin n_err++; $display("FAIL wrap_waits got %0d want 1", w); end
      n_cmp++; if ({r0, r1} !== 2'b00) begin n_err++; $display("FAIL wrap_resp got %b want 00", {r0, r1}); end
`endif
      n_cmp++; if (hresp !== 1'b0) begin n_err++; $display("FAIL err_idle_resp got %b want 0", hresp); end
      n_cmp++; if (xfer_cnt !== exp_cnt) begin n_err++; $display("FAIL err_cnt got %0d want %0d", xfer_cnt, exp_cnt); end
      bus_xfer(1'b0, 32'h0, 32'h0, w, rd, r0, r1);
      exp_cnt++;
`ifdef DMAC_AHB_SLV_ERR_EN
      n_cmp++; if (rd !== 32'h77) begin n_err++; $display("FAIL err_mem got %h want 77", rd); end
`else
      n_cmp++; if (rd !== 32'h5) begin n_err++; $display("FAIL wrap_mem got %h want 5", rd); end
`endif
   endtask

   task automatic test_idle_busy();
      hsel = 1'b1; hwrite = 1'b1; haddr = 32'h40;
      for (int i = 0; i < 6; i++) begin
         htrans = (i < 4) ? 2'b00 : 2'b01;
         tick();
         n_cmp++; if (hreadyout !== 1'b1 || hresp !== 1'b0) begin
            n_err++; $display("FAIL idle_ready cycle %0d got rdy=%b resp=%b want 1/0", i, hreadyout, hresp);
         end
      end
      hsel = 1'b0; htrans = 2'b00; hwrite = 1'b0;
      tick();
      n_cmp++; if (xfer_cnt !== exp_cnt) begin n_err++; $display("FAIL idle_cnt got %0d want %0d", xfer_cnt, exp_cnt); end
   endtask

   task automatic test_reset_mid_phase();
      int w; logic [31:0] rd; logic r0, r1;
      bus_xfer(1'b1, 32'h20, 32'h11111111, w, rd, r0, r1);
      hsel = 1'b1; htrans = 2'b10; hwrite = 1'b1; haddr = 32'h20;
      tick();
      hsel = 1'b0; htrans = 2'b00; hwrite = 1'b0; hwdata = 32'hA5A5A5A5;
      n_cmp++; if (hreadyout !== 1'b0) begin n_err++; $display("FAIL abort_wait got %b want 0", hreadyout); end
      rst = 1'b1;
      tick();
      rst = 1'b0;
      exp_cnt = 16'd0;
      n_cmp++; if (hreadyout !== 1'b1) begin n_err++; $display("FAIL abort_ready got %b want 1", hreadyout); end
      n_cmp++; if (xfer_cnt !== 16'd0) begin n_err++; $display("FAIL abort_cnt got %0d want 0", xfer_cnt); end
      tick();
      bus_xfer(1'b0, 32'h20, 32'h0, w, rd, r0, r1);
      exp_cnt++;
      n_cmp++; if (rd !== 32'h11111111) begin n_err++; $display("FAIL abort_mem got %h want 11111111", rd); end
      n_cmp++; if (xfer_cnt !== exp_cnt) begin n_err++; $display("FAIL abort_rd_cnt got %0d want %0d", xfer_cnt, exp_cnt); end
   endtask

   initial begin
      rst = 1'b1; hsel = 1'b0; hsel0 = 1'b0; htrans = 2'b00; hsize = 3'b010;
      hwrite = 1'b0; haddr = 32'h0; hwdata = 32'h0; exp_cnt = 16'd0;
      test_reset();
      test_write_read();
      test_back_to_back();
      test_error();
      test_idle_busy();
      test_reset_mid_phase();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
